// File: rtl/risc16_fetch_if.sv
// ---------------------------------------------------------------------------
// risc16_fetch_if
//
// Bundles the fetch unit's two external buses:
//   * instruction-memory read port : imem_en, imem_addr (to memory),
//                                    imem_data (from memory, one cycle later)
//   * core-side port               : redirect, redirect_pc, out_ready (from core),
//                                    out_valid, out_instr, out_pc (to core)
//
// Modports:
//   master - the fetch unit itself
//   slave  - the environment (instruction memory + decode/execute stage)
// ---------------------------------------------------------------------------
interface risc16_fetch_if #(
    parameter int ADDR_W = 16
);
    // Instruction memory read port
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;

    // Core control-flow redirect
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // Instruction hand-off to the core
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_en, imem_addr,
        input  imem_data,
        input  redirect, redirect_pc,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_data,
        output redirect, redirect_pc,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface

// File: rtl/risc16_fetch.sv
// ---------------------------------------------------------------------------
// risc16_fetch
//
// Instruction-fetch front end for the RISC16 core. Holds the fetch PC, issues
// word reads to a synchronous instruction memory, buffers returned words in a
// DEPTH-entry prefetch queue and presents instruction/PC pairs to the core
// over a valid/ready handshake. A redirect from the core flushes the queue and
// drops any read still in flight.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - risc16_fetch_if.master
//            imem_en/imem_addr   : read request (combinational)
//            imem_data           : read data, valid the cycle after imem_en
//            redirect/redirect_pc: restart fetch at redirect_pc
//            out_valid/out_ready : hand-off handshake
//            out_instr/out_pc    : queue head contents (0 while empty)
// ---------------------------------------------------------------------------
module risc16_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst,
    risc16_fetch_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Control state
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
    logic              pending_q,  pending_d;
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic [CNT_W-1:0]  count_q,    count_d;

    // Queue storage (data only, never reset)
    logic [15:0]       instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic              not_empty;
    logic [CNT_W-1:0]  credit;

    always_comb begin
        not_empty = (count_q != '0);

        // Slots already promised: stored words plus the read in flight.
        // A pop this cycle is deliberately not credited, keeping the
        // issue decision independent of out_ready.
        credit = count_q + CNT_W'(pending_q);
        issue  = !rst && !bus.redirect && (credit < CNT_W'(DEPTH));

        // A redirect discards the word returning this cycle.
        push   = pending_q && !rst && !bus.redirect;
        pop    = not_empty && bus.out_ready;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        pending_d  = issue;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            req_pc_d   = fetch_pc_q;
        end

        if (bus.redirect) begin
            // Flush wins over push/pop; a pop in this cycle was still
            // consumed by the core, its entry simply disappears with the rest.
            fetch_pc_d = bus.redirect_pc;
            pending_d  = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            pending_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            pending_q  <= pending_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[tail_q] <= bus.imem_data;
            pc_q[tail_q]    <= req_pc_q;
        end
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = not_empty;
    // Head storage is masked while empty so stale entries never show.
    assign bus.out_instr = not_empty ? instr_q[head_q] : '0;
    assign bus.out_pc    = not_empty ? pc_q[head_q]    : '0;

endmodule

// File: tb/tb_risc16_fetch.sv
// ---------------------------------------------------------------------------
// tb_risc16_fetch
//
// Directed bench for risc16_fetch. Two instances: dut (RESET_PC=0) exercises
// streaming, backpressure, redirects and mid-run reset; dut_w (RESET_PC=FFFE)
// exercises PC wrap. Memory model returns mem[a] = a ^ 16'hA500.
// Expected hand-offs are queued by the stimulus; monitors pop and compare on
// each accepted output.
// ---------------------------------------------------------------------------
module tb_risc16_fetch;
    logic clk;
    logic rst;

    risc16_fetch_if #(.ADDR_W(16)) bus   ();
    risc16_fetch_if #(.ADDR_W(16)) bus_w ();

    risc16_fetch #(.ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    risc16_fetch #(.ADDR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory models
    always_ff @(posedge clk) begin
        if (bus.imem_en) bus.imem_data <= bus.imem_addr ^ 16'hA500;
    end
    always_ff @(posedge clk) begin
        if (bus_w.imem_en) bus_w.imem_data <= bus_w.imem_addr ^ 16'hA500;
    end

    int n_chk;
    int n_pass;
    int pop_cnt;
    int pop_cnt_w;
    int en_cnt;
    logic [15:0] en_addrs[$];
    logic [31:0] sb[$];     // {pc, instr}
    logic [31:0] sb_w[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [15:0] pc, input int n);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc + 16'(i);
            sb.push_back({p, p ^ 16'hA500});
        end
    endtask

    task automatic push_exp_w(input logic [15:0] pc, input int n);
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc + 16'(i);
            sb_w.push_back({p, p ^ 16'hA500});
        end
    endtask

    // Scoreboard monitors
    initial begin
        logic [31:0] item;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pop: got pc %h, required no hand-off", bus.out_pc);
                end else begin
                    item = sb.pop_front();
                    chk("pop_pc", 32'(bus.out_pc), 32'(item[31:16]));
                    chk("pop_instr", 32'(bus.out_instr), 32'(item[15:0]));
                end
            end
        end
    end

    initial begin
        logic [31:0] item;
        forever begin
            @(negedge clk);
            if (bus_w.out_valid && bus_w.out_ready) begin
                pop_cnt_w++;
                if (sb_w.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pop_w: got pc %h, required no hand-off", bus_w.out_pc);
                end else begin
                    item = sb_w.pop_front();
                    chk("pop_pc_w", 32'(bus_w.out_pc), 32'(item[31:16]));
                    chk("pop_instr_w", 32'(bus_w.out_instr), 32'(item[15:0]));
                end
            end
        end
    end

    // Request monitor for dut
    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_en) begin
                en_cnt++;
                en_addrs.push_back(bus.imem_addr);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Holds rst for n cycles; returns at the start of c0.
    task automatic do_reset(input int n);
        bus.out_ready   = 1'b0;
        bus_w.out_ready = 1'b0;
        bus.redirect    = 1'b0;
        rst             = 1'b1;
        for (int i = 0; i < n; i++) begin
            mid();
            chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
            if (i > 0) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_out_instr", 32'(bus.out_instr), 32'd0);
                chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
            end
            next_cyc();
        end
        rst = 1'b0;
        sb.delete();
        sb_w.delete();
        en_addrs.delete();
        pop_cnt   = 0;
        pop_cnt_w = 0;
        en_cnt    = 0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.out_ready = 1'b0;
        bus_w.redirect = 1'b0;
        bus_w.redirect_pc = 16'h0000;
        bus_w.out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset then stream
        do_reset(2);
        push_exp(16'h0000, 8);
        bus.out_ready = 1'b1;
        mid();
        chk("c0_imem_en", 32'(bus.imem_en), 32'd1);
        chk("c0_imem_addr", 32'(bus.imem_addr), 32'h0000);
        chk("c0_out_valid", 32'(bus.out_valid), 32'd0);
        next_cyc(); mid();
        chk("c1_out_valid", 32'(bus.out_valid), 32'd0);
        next_cyc(); mid();
        chk("c2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("c2_out_pc", 32'(bus.out_pc), 32'h0000);
        repeat (8) next_cyc();
        bus.out_ready = 1'b0;
        mid();
        chk("stream_pops", 32'(pop_cnt), 32'd8);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: fill, then drain
        next_cyc();
        do_reset(1);
        repeat (9) next_cyc();
        mid();
        chk("full_en_pulses", 32'(en_cnt), 32'd4);
        for (int i = 0; i < en_addrs.size(); i++)
            chk("full_en_addr", 32'(en_addrs[i]), 32'(i));
        chk("full_imem_en", 32'(bus.imem_en), 32'd0);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_out_pc", 32'(bus.out_pc), 32'h0000);
        chk("full_out_instr", 32'(bus.out_instr), 32'h0000A500);
        push_exp(16'h0000, 6);
        next_cyc();
        bus.out_ready = 1'b1;
        repeat (6) next_cyc();
        bus.out_ready = 1'b0;
        mid();
        chk("drain_pops", 32'(pop_cnt), 32'd6);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Redirect mid-stream with a pop and an in-flight read in the same cycle
        next_cyc();
        do_reset(1);
        push_exp(16'h0000, 3);
        push_exp(16'h0040, 3);
        bus.out_ready = 1'b1;
        repeat (4) next_cyc();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        mid();
        chk("redir_t_imem_en", 32'(bus.imem_en), 32'd0);
        next_cyc();
        bus.redirect = 1'b0;
        mid();
        chk("redir_t1_imem_en", 32'(bus.imem_en), 32'd1);
        chk("redir_t1_addr", 32'(bus.imem_addr), 32'h0040);
        chk("redir_t1_valid", 32'(bus.out_valid), 32'd0);
        next_cyc(); mid();
        chk("redir_t2_valid", 32'(bus.out_valid), 32'd0);
        next_cyc(); mid();
        chk("redir_t3_valid", 32'(bus.out_valid), 32'd1);
        chk("redir_t3_pc", 32'(bus.out_pc), 32'h0040);
        repeat (3) next_cyc();
        bus.out_ready = 1'b0;
        mid();
        chk("redir_pops", 32'(pop_cnt), 32'd6);
        chk("redir_sb_empty", 32'(sb.size()), 32'd0);

        // Back-to-back redirects: last one wins
        next_cyc();
        do_reset(1);
        push_exp(16'h0200, 2);
        repeat (3) next_cyc();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0100;
        next_cyc();
        bus.redirect_pc = 16'h0200;
        mid();
        chk("b2b_imem_en", 32'(bus.imem_en), 32'd0);
        next_cyc();
        bus.redirect = 1'b0;
        mid();
        chk("b2b_t1_imem_en", 32'(bus.imem_en), 32'd1);
        chk("b2b_t1_addr", 32'(bus.imem_addr), 32'h0200);
        chk("b2b_t1_valid", 32'(bus.out_valid), 32'd0);
        next_cyc();
        next_cyc();
        bus.out_ready = 1'b1;
        mid();
        chk("b2b_t3_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_t3_pc", 32'(bus.out_pc), 32'h0200);
        next_cyc();
        next_cyc();
        bus.out_ready = 1'b0;
        mid();
        chk("b2b_pops", 32'(pop_cnt), 32'd2);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with the queue full, then standard restart
        next_cyc();
        do_reset(1);
        repeat (9) next_cyc();
        mid();
        chk("pre_rst_full_valid", 32'(bus.out_valid), 32'd1);
        next_cyc();
        do_reset(1);
        push_exp(16'h0000, 3);
        bus.out_ready = 1'b1;
        mid();
        chk("rr_c0_valid", 32'(bus.out_valid), 32'd0);
        chk("rr_c0_imem_en", 32'(bus.imem_en), 32'd1);
        chk("rr_c0_addr", 32'(bus.imem_addr), 32'h0000);
        next_cyc(); mid();
        chk("rr_c1_valid", 32'(bus.out_valid), 32'd0);
        next_cyc(); mid();
        chk("rr_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("rr_c2_pc", 32'(bus.out_pc), 32'h0000);
        repeat (3) next_cyc();
        bus.out_ready = 1'b0;
        mid();
        chk("rr_pops", 32'(pop_cnt), 32'd3);
        chk("rr_sb_empty", 32'(sb.size()), 32'd0);

        // PC wrap on the FFFE-reset instance
        next_cyc();
        do_reset(1);
        push_exp_w(16'hFFFE, 4);
        bus_w.out_ready = 1'b1;
        mid();
        chk("wrap_c0_imem_en", 32'(bus_w.imem_en), 32'd1);
        chk("wrap_c0_addr", 32'(bus_w.imem_addr), 32'h0000FFFE);
        next_cyc();
        next_cyc();
        mid();
        chk("wrap_c2_valid", 32'(bus_w.out_valid), 32'd1);
        chk("wrap_c2_pc", 32'(bus_w.out_pc), 32'h0000FFFE);
        repeat (4) next_cyc();
        bus_w.out_ready = 1'b0;
        mid();
        chk("wrap_pops", 32'(pop_cnt_w), 32'd4);
        chk("wrap_sb_empty", 32'(sb_w.size()), 32'd0);

        next_cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
